uart_rx_fifo: RTL and testbench

- Serial receive front end for the UART path.
- Oversamples `RsRx` at 16× the baud rate, validates the start bit, and deserialises 8N1 frames (LSB first).
- Pushes each good byte into a first-word-fall-through FIFO.
- Sits directly upstream of the UART input manager, which pops bytes via `rd_en` to assemble numbers for the main FSM.

---
 rtl/uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver feeding a first-word-fall-through byte FIFO
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (default build is 8N1).
module uart_rx_fifo #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RsRx,
  input  logic                        rd_en,
  output logic [7:0]                  data_out,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int DIV  = CLOCK_RATE / (BAUD_RATE * 16);
  localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

  logic            r_sync1, r_sync2;
  logic            w_rx;
  logic [DIVW-1:0] r_div;
  logic            w_tick, w_start;
  state_t          r_state, w_state_next;
  logic [3:0]      r_samp, w_samp_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_s7, r_s8, w_s7_next, w_s8_next;
  logic            w_maj, w_mid, w_end, w_par_ok;
  logic            w_commit, w_bad;
  logic            r_wr, r_frame_err, r_overrun;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            w_empty, w_full, w_do_rd, w_do_wr;

`ifdef UART_RX_PARITY_EN
  logic            r_par_err, w_par_err_next;
  assign w_par_ok = !r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_rx   = r_sync2;
  assign w_tick = (r_div == DIVW'(DIV - 1));
  assign w_mid  = w_tick && (r_samp == 4'd9);
  assign w_end  = w_tick && (r_samp == 4'd15);
  // Majority vote; the third sample is the live line at sample count 9.
  assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RsRx;
      r_sync2 <= r_sync1;
    end
  end

  // Oversample tick divider, re-phased to the detected start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_div <= '0;
    else if (w_start || w_tick) r_div <= '0;
    else                       r_div <= r_div + DIVW'(1);
  end

  // Receiver next-state, sampling and frame decision logic.
  always_comb begin
    w_state_next = r_state;
    w_samp_next  = r_samp;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_s7_next    = r_s7;
    w_s8_next    = r_s8;
    w_commit     = 1'b0;
    w_bad        = 1'b0;
    w_start      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_next = r_par_err;
`endif
    if (r_state != S_IDLE && r_state != S_WAIT_HIGH && w_tick) begin
      w_samp_next = r_samp + 4'd1;
      if (r_samp == 4'd7) w_s7_next = w_rx;
      if (r_samp == 4'd8) w_s8_next = w_rx;
    end
    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_state_next = S_START;
          w_samp_next  = 4'd0;
          w_bit_next   = 3'd0;
          w_start      = 1'b1;
`ifdef UART_RX_PARITY_EN
          w_par_err_next = 1'b0;
`endif
        end
      end
      S_START: begin
        if (w_mid && w_maj) w_state_next = S_IDLE;
        else if (w_end)     w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_mid) w_shift_next = {w_maj, r_shift[7:1]};
        if (w_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_mid) w_par_err_next = (w_maj != ^r_shift);
        if (w_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_mid) begin
          if (w_maj && w_par_ok) begin
            w_commit     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_bad        = 1'b1;
            w_state_next = w_maj ? S_IDLE : S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_samp  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_s7    <= 1'b1;
      r_s8    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_samp  <= w_samp_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_s7    <= w_s7_next;
      r_s8    <= w_s8_next;
`ifdef UART_RX_PARITY_EN
      r_par_err <= w_par_err_next;
`endif
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_do_rd = rd_en && !w_empty;
  // A read on the same edge frees the slot, so a full FIFO still accepts.
  assign w_do_wr = r_wr && (!w_full || w_do_rd);

  // Write strobe and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr        <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wr        <= w_commit;
      r_frame_err <= w_bad;
      r_overrun   <= r_wr && w_full && !w_do_rd;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= r_shift;
  end

  assign data_out  = w_empty ? 8'h00 : r_mem[r_rptr];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with a byte-queue reference model
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLOCK_RATE = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int FIFO_DEPTH = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_CLKS   = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          RsRx = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    data_out;
  logic          empty, full;
  logic [CW-1:0] count;
  logic          frame_err, overrun;

  uart_rx_fifo #(
    .CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .RsRx(RsRx), .rd_en(rd_en),
    .data_out(data_out), .empty(empty), .full(full), .count(count),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0, exp_ovr = 0, seen_ferr = 0, seen_ovr = 0;
  bit         consume_en = 1'b0;
  int         pop_at = -1;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: counts pulses and pops the DUT, comparing each head byte with the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (frame_err) seen_ferr++;
      if (overrun) seen_ovr++;
      rd_en = 1'b0;
      if (!empty && ((consume_en && $urandom_range(1, 0) == 1) || cyc == pop_at)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop: got unexpected byte 0x%0h expected no byte", data_out);
        end else begin
          check("pop data", int'(data_out), int'(exp_q.pop_front()));
        end
        rd_en = 1'b1;
      end
    end
  end

  // Drives one frame on the line, LSB first; must be called at a falling clock edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    logic [10:0] bits;
    bits       = '1;
    bits[0]    = 1'b0;
    bits[8:1]  = b;
    bits[9]    = PAR_EN ? ((^b) ^ par_flip) : stop_bit;
    bits[10]   = stop_bit;
    for (int i = 0; i < FRAME_BITS; i++) begin
      RsRx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  // Reference model: a good frame becomes a queued byte unless the FIFO already holds DEPTH.
  task automatic frame(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    bit good;
    good = stop_bit && !(PAR_EN && par_flip);
    if (!good)                          exp_ferr++;
    else if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
    else                                exp_ovr++;
    send_frame(b, stop_bit, par_flip);
  endtask

  task automatic idle(input int n);
    RsRx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    consume_en = 1'b1;
    for (int i = 0; i < 600 && !(exp_q.size() == 0 && empty); i++) @(negedge clk);
    check({name, " drained empty"}, int'(empty), 1);
    check({name, " model leftover"}, exp_q.size(), 0);
    consume_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] b;
    bit         sb, pf;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset empty", int'(empty), 1);
    check("reset full", int'(full), 0);
    check("reset count", int'(count), 0);
    check("reset data_out", int'(data_out), 0);
    check("reset frame_err", int'(frame_err), 0);
    check("reset overrun", int'(overrun), 0);
    reset = 1'b1;
    idle(4);

    // Single byte
    frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    check("single empty", int'(empty), 0);
    check("single count", int'(count), 1);
    check("single data_out", int'(data_out), 8'hA5);
    check("single no frame_err", seen_ferr, 0);
    check("single no overrun", seen_ovr, 0);
    drain("single");

    // Fill and overrun
    for (int i = 0; i < 17; i++) begin
      b = 8'(i);
      frame(b, 1'b1, 1'b0);
      idle(1);
      check("fill count", int'(count), exp_q.size());
      check("fill full", int'(full), int'(exp_q.size() == FIFO_DEPTH));
    end
    check("fill overrun pulses", seen_ovr, exp_ovr);
    check("fill overrun expected one", exp_ovr, 1);
    drain("fill");

    // Bad stop bit, line held low, then a good byte
    frame(8'h3C, 1'b0, 1'b0);
    RsRx = 1'b0;
    repeat (40) @(negedge clk);
    idle(5);
    frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    check("badstop frame_err", seen_ferr, exp_ferr);
    check("badstop count", int'(count), 1);
    check("badstop data_out", int'(data_out), 8'h5A);
    drain("badstop");

    // False start glitch
    RsRx = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("glitch count", int'(count), 0);
    check("glitch frame_err", seen_ferr, exp_ferr);
    frame(8'h81, 1'b1, 1'b0);
    idle(4);
    check("glitch next data", int'(data_out), 8'h81);
    drain("glitch");

    // Reset mid-frame with a byte already stored
    frame(8'h44, 1'b1, 1'b0);
    idle(2);
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BIT_CLKS * 4 + 5) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("midreset empty", int'(empty), 1);
        check("midreset count", int'(count), 0);
        check("midreset data_out", int'(data_out), 0);
        reset = 1'b1;
      end
    join
    idle(4);
    frame(8'h12, 1'b1, 1'b0);
    idle(4);
    check("postreset count", int'(count), 1);
    check("postreset data", int'(data_out), 8'h12);
    drain("postreset");

    // Full FIFO with a pop on the commit edge
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      b = 8'(8'h80 + i);
      frame(b, 1'b1, 1'b0);
    end
    idle(2);
    check("boundary full", int'(full), 1);
    check("boundary count", int'(count), FIFO_DEPTH);
    exp_q.push_back(8'hC3);
    pop_at = cyc + BIT_CLKS * (FRAME_BITS - 1) + 13;
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(3);
    pop_at = -1;
    check("boundary count kept", int'(count), FIFO_DEPTH);
    check("boundary no overrun", seen_ovr, exp_ovr);
    drain("boundary");

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0);
    frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("parity count", int'(count), 1);
    check("parity data", int'(data_out), 8'h07);
    check("parity frame_err", seen_ferr, exp_ferr);
    drain("parity");
`endif

    // Randomised traffic with a concurrently consuming monitor
    consume_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(7, 0) != 0);
      pf = PAR_EN && ($urandom_range(7, 0) == 0);
      frame(b, sb, pf);
      if (!sb || pf) idle($urandom_range(8, 2));
      else           idle($urandom_range(3, 0));
    end
    drain("random");
    check("final frame_err", seen_ferr, exp_ferr);
    check("final overrun", seen_ovr, exp_ovr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
